// File: rtl/pin_mux_sync.sv
// Registered pin-multiplexing fabric between the pad ring and peripheral ports.
// Each pin has a function select, an input synchroniser and a tristate guard on function changes.
module pin_mux_sync #(
  parameter  int COUNT       = 32,
  parameter  int FUNCS       = 4,
  parameter  int SELW        = 2,
  parameter  int SYNC_STAGES = 2,
  parameter  int GUARD       = 4,
  localparam int ADDRW       = (COUNT > 1) ? $clog2(COUNT) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [COUNT-1:0]         io_in,
  output logic [COUNT-1:0]         io_out,
  output logic [COUNT-1:0]         io_oeb,
  output logic [COUNT*FUNCS-1:0]   p_in,
  input  logic [COUNT*FUNCS-1:0]   p_out,
  input  logic [COUNT*FUNCS-1:0]   p_oeb,
  input  logic                     cfg_we,
  input  logic [ADDRW-1:0]         cfg_addr,
  input  logic [SELW-1:0]          cfg_wdata,
  input  logic                     cfg_lock,
  output logic [SELW-1:0]          cfg_rdata,
  output logic                     cfg_busy,
  output logic                     cfg_err,
  output logic                     locked
);

  typedef enum logic {
    ST_ACTIVE = 1'b0,
    ST_GUARD  = 1'b1
  } pin_state_t;

  localparam logic [SELW:0]  FUNCS_L      = (SELW+1)'(FUNCS);
  localparam logic [ADDRW:0] COUNT_L      = (ADDRW+1)'(COUNT);
  localparam logic [7:0]     GUARD_RELOAD = 8'(GUARD - 1);

  logic [COUNT-1:0] r_sync [SYNC_STAGES];
  logic [COUNT-1:0] w_sync_out;
  logic             r_locked;
  logic             r_err;
  logic             w_accept;
  logic             w_addr_ok;
  logic [SELW-1:0]  w_sel_all [COUNT];
  logic [COUNT-1:0] w_busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= '0;
      end
    end else begin
      r_sync[0] <= io_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  assign w_sync_out = r_sync[SYNC_STAGES-1];

  // The write is judged against the lock value held before this edge.
  assign w_addr_ok = ({1'b0, cfg_addr} < COUNT_L);
  assign w_accept  = cfg_we && !r_locked && w_addr_ok && ({1'b0, cfg_wdata} < FUNCS_L);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_locked <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_locked <= r_locked | cfg_lock;
      r_err    <= cfg_we & ~w_accept;
    end
  end

  generate
    for (genvar gi = 0; gi < COUNT; gi++) begin : g_pin
      pin_state_t       r_state;
      pin_state_t       w_state_next;
      logic [SELW-1:0]  r_sel;
      logic [SELW-1:0]  w_sel_next;
      logic [7:0]       r_cnt;
      logic [7:0]       w_cnt_next;
      logic             w_change;
      logic             r_out;
      logic             r_oeb;
      logic [FUNCS-1:0] w_pout;
      logic [FUNCS-1:0] w_poeb;
      logic [FUNCS-1:0] w_pin;

      assign w_change = w_accept && (cfg_addr == ADDRW'(gi)) && (cfg_wdata != r_sel);
      assign w_pout   = p_out[gi*FUNCS +: FUNCS];
      assign w_poeb   = p_oeb[gi*FUNCS +: FUNCS];

      always_comb begin
        w_state_next = r_state;
        w_sel_next   = r_sel;
        w_cnt_next   = r_cnt;
        if (w_change) begin
          w_state_next = ST_GUARD;
          w_sel_next   = cfg_wdata;
          w_cnt_next   = GUARD_RELOAD;
        end else if (r_state == ST_GUARD) begin
          if (r_cnt == 8'd0) begin
            w_state_next = ST_ACTIVE;
          end else begin
            w_cnt_next = r_cnt - 8'd1;
          end
        end
      end

      // Pad drive follows the next-state select, so the old function is off the pad from the write edge.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_state <= ST_ACTIVE;
          r_sel   <= '0;
          r_cnt   <= 8'd0;
          r_out   <= 1'b0;
          r_oeb   <= 1'b1;
        end else begin
          r_state <= w_state_next;
          r_sel   <= w_sel_next;
          r_cnt   <= w_cnt_next;
          if (w_state_next == ST_GUARD) begin
            r_out <= 1'b0;
            r_oeb <= 1'b1;
          end else begin
            r_out <= w_pout[w_sel_next];
            r_oeb <= w_poeb[w_sel_next];
          end
        end
      end

      always_comb begin
        w_pin = '0;
        if (r_state == ST_ACTIVE) begin
          w_pin[r_sel] = w_sync_out[gi];
        end
      end

      assign p_in[gi*FUNCS +: FUNCS] = w_pin;
      assign io_out[gi]              = r_out;
      assign io_oeb[gi]              = r_oeb;
      assign w_busy[gi]              = (r_state == ST_GUARD);
      assign w_sel_all[gi]           = r_sel;
    end
  endgenerate

  assign cfg_rdata = w_addr_ok ? w_sel_all[cfg_addr] : '0;
  assign cfg_busy  = |w_busy;
  assign cfg_err   = r_err;
  assign locked    = r_locked;

endmodule

// File: tb/tb_pin_mux_sync.sv
// Directed bench for pin_mux_sync: a 32x4 instance for switching, lock and reset,
// and a 6x3 instance for rejected writes on a non-power-of-two function count.
module tb_pin_mux_sync;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: COUNT=32, FUNCS=4
  logic [31:0]  a_io_in, a_io_out, a_io_oeb;
  logic [127:0] a_p_in, a_p_out, a_p_oeb;
  logic         a_we, a_lock, a_busy, a_err, a_locked;
  logic [4:0]   a_addr;
  logic [1:0]   a_wdata, a_rdata;

  // Instance B: COUNT=6, FUNCS=3
  logic [5:0]   b_io_in, b_io_out, b_io_oeb;
  logic [17:0]  b_p_in, b_p_out, b_p_oeb;
  logic         b_we, b_lock, b_busy, b_err, b_locked;
  logic [2:0]   b_addr;
  logic [1:0]   b_wdata, b_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  pin_mux_sync #(.COUNT(32), .FUNCS(4), .SELW(2), .SYNC_STAGES(2), .GUARD(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .io_in(a_io_in), .io_out(a_io_out), .io_oeb(a_io_oeb),
    .p_in(a_p_in), .p_out(a_p_out), .p_oeb(a_p_oeb), .cfg_we(a_we), .cfg_addr(a_addr),
    .cfg_wdata(a_wdata), .cfg_lock(a_lock), .cfg_rdata(a_rdata), .cfg_busy(a_busy),
    .cfg_err(a_err), .locked(a_locked)
  );

  pin_mux_sync #(.COUNT(6), .FUNCS(3), .SELW(2), .SYNC_STAGES(2), .GUARD(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .io_in(b_io_in), .io_out(b_io_out), .io_oeb(b_io_oeb),
    .p_in(b_p_in), .p_out(b_p_out), .p_oeb(b_p_oeb), .cfg_we(b_we), .cfg_addr(b_addr),
    .cfg_wdata(b_wdata), .cfg_lock(b_lock), .cfg_rdata(b_rdata), .cfg_busy(b_busy),
    .cfg_err(b_err), .locked(b_locked)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    a_io_in = '0; a_p_out = '0; a_p_oeb = '1;
    a_we = 1'b0; a_lock = 1'b0; a_addr = '0; a_wdata = '0;
    b_io_in = '0; b_p_out = '0; b_p_oeb = '1;
    b_we = 1'b0; b_lock = 1'b0; b_addr = '0; b_wdata = '0;
    a_p_out[0] = 1'b1;
    a_p_oeb[0] = 1'b0;

    // Reset state
    tick();
    check("rst_oeb",    64'(a_io_oeb), 64'h0000_0000_FFFF_FFFF);
    check("rst_out",    64'(a_io_out), 64'h0);
    check("rst_pin",    64'(a_p_in[63:0]), 64'h0);
    check("rst_busy",   64'(a_busy),   64'h0);
    check("rst_err",    64'(a_err),    64'h0);
    check("rst_locked", 64'(a_locked), 64'h0);
    rst_n = 1'b1;
    tick();
    check("post_rst_oeb", 64'(a_io_oeb), 64'h0000_0000_FFFF_FFFE);
    check("post_rst_out", 64'(a_io_out), 64'h1);
    a_io_in[5] = 1'b1;
    for (int i = 0; i < 32; i++) begin
      a_addr = 5'(i);
      #1;
      check($sformatf("rst_rdata%0d", i), 64'(a_rdata), 64'h0);
    end
    tick();
    tick();
    check("pin5_f0_in", 64'(a_p_in[23:20]), 64'h1);

    // Function switch: pin 5 -> 2, guard of 4 cycles
    a_p_oeb[22] = 1'b0;
    a_p_out[22] = 1'b1;
    a_we = 1'b1; a_addr = 5'd5; a_wdata = 2'd2;
    tick();
    a_we = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("g5_oeb%0d", k),  64'(a_io_oeb[5]), 64'h1);
      check($sformatf("g5_busy%0d", k), 64'(a_busy),      64'h1);
      check($sformatf("g5_pin%0d", k),  64'(a_p_in[23:20]), 64'h0);
      if (k < 3) tick();
    end
    tick();
    check("g5_end_oeb",  64'(a_io_oeb[5]), 64'h0);
    check("g5_end_out",  64'(a_io_out[5]), 64'h1);
    check("g5_end_busy", 64'(a_busy),      64'h0);
    check("g5_rdata",    64'(a_rdata),     64'h2);
    check("g5_pin_f2",   64'(a_p_in[23:20]), 64'h4);
    a_io_in[5] = 1'b0;
    tick();
    check("sync_lat1", 64'(a_p_in[23:20]), 64'h4);
    tick();
    check("sync_lat2", 64'(a_p_in[23:20]), 64'h0);

    // Same-value write while ACTIVE is a silent no-op
    a_we = 1'b1; a_addr = 5'd5; a_wdata = 2'd2;
    tick();
    a_we = 1'b0;
    check("noop_busy", 64'(a_busy),      64'h0);
    check("noop_err",  64'(a_err),       64'h0);
    check("noop_oeb",  64'(a_io_oeb[5]), 64'h0);

    // Re-write mid-guard: pin 3 -> 1, two cycles later pin 3 -> 3
    a_p_oeb[15] = 1'b0;
    a_p_out[15] = 1'b1;
    a_we = 1'b1; a_addr = 5'd3; a_wdata = 2'd1;
    tick();
    a_we = 1'b0;
    check("rw_oeb0",   64'(a_io_oeb[3]), 64'h1);
    check("rw_rdata1", 64'(a_rdata),     64'h1);
    tick();
    check("rw_oeb1", 64'(a_io_oeb[3]), 64'h1);
    a_we = 1'b1; a_wdata = 2'd3;
    tick();
    a_we = 1'b0;
    check("rw_oeb2",   64'(a_io_oeb[3]), 64'h1);
    check("rw_rdata3", 64'(a_rdata),     64'h3);
    for (int k = 3; k < 6; k++) begin
      tick();
      check($sformatf("rw_oeb%0d", k), 64'(a_io_oeb[3]), 64'h1);
    end
    tick();
    check("rw_end_oeb",  64'(a_io_oeb[3]), 64'h0);
    check("rw_end_out",  64'(a_io_out[3]), 64'h1);
    check("rw_end_busy", 64'(a_busy),      64'h0);

    // Rejected writes on the FUNCS=3 instance
    b_we = 1'b1; b_addr = 3'd0; b_wdata = 2'd3;
    tick();
    b_we = 1'b0;
    check("err_func",      64'(b_err),   64'h1);
    check("err_func_busy", 64'(b_busy),  64'h0);
    check("err_func_sel",  64'(b_rdata), 64'h0);
    tick();
    check("err_func_pulse", 64'(b_err), 64'h0);
    b_we = 1'b1; b_addr = 3'd6; b_wdata = 2'd1;
    tick();
    b_we = 1'b0;
    check("err_addr",      64'(b_err),  64'h1);
    check("err_addr_busy", 64'(b_busy), 64'h0);
    tick();
    check("err_addr_pulse", 64'(b_err), 64'h0);
    b_we = 1'b1; b_addr = 3'd5; b_wdata = 2'd2;
    tick();
    b_we = 1'b0;
    check("b_ok_err",   64'(b_err),   64'h0);
    check("b_ok_busy",  64'(b_busy),  64'h1);
    check("b_ok_rdata", 64'(b_rdata), 64'h2);

    // Lock together with a write of pin 1 -> 2
    a_we = 1'b1; a_lock = 1'b1; a_addr = 5'd1; a_wdata = 2'd2;
    tick();
    a_we = 1'b0; a_lock = 1'b0;
    check("lock_set",   64'(a_locked), 64'h1);
    check("lock_wr_ok", 64'(a_err),    64'h0);
    check("lock_rdata", 64'(a_rdata),  64'h2);
    check("lock_busy",  64'(a_busy),   64'h1);
    repeat (4) tick();
    check("lock_guard_done", 64'(a_busy), 64'h0);
    a_we = 1'b1; a_addr = 5'd1; a_wdata = 2'd0;
    tick();
    a_we = 1'b0;
    check("locked_err",   64'(a_err),    64'h1);
    check("locked_rdata", 64'(a_rdata),  64'h2);
    check("locked_busy",  64'(a_busy),   64'h0);
    check("locked_hold",  64'(a_locked), 64'h1);
    tick();
    check("locked_err_pulse", 64'(a_err), 64'h0);

    // Reset clears the lock
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("unlock", 64'(a_locked), 64'h0);

    // Reset two cycles into a guard on pin 7
    a_p_oeb[28] = 1'b0;
    a_p_out[28] = 1'b1;
    a_we = 1'b1; a_addr = 5'd7; a_wdata = 2'd1;
    tick();
    a_we = 1'b0;
    check("p7_err",  64'(a_err),  64'h0);
    check("p7_busy", 64'(a_busy), 64'h1);
    tick();
    rst_n = 1'b0;
    tick();
    check("midrst_busy", 64'(a_busy),      64'h0);
    check("midrst_oeb",  64'(a_io_oeb[7]), 64'h1);
    rst_n = 1'b1;
    tick();
    check("p7_rdata", 64'(a_rdata),     64'h0);
    check("p7_busy0", 64'(a_busy),      64'h0);
    check("p7_oeb",   64'(a_io_oeb[7]), 64'h0);
    check("p7_out",   64'(a_io_out[7]), 64'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
